// File: rtl/lsu_pkg.sv
// Shared LSU types: FSM state, RV32 load/store funct3 codes, per-access descriptor
// and the legality, alignment and split-access helpers.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_e;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
   } mem_acc_t;

   function automatic logic is_illegal(input logic [2:0] f3, input logic we);
      return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (f3[2] && we);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
   endfunction

   // Index of the final access: 0 when unsplit, else 1 (halfword) or 3 (word).
   function automatic logic [1:0] last_idx(input logic [2:0] f3, input logic split);
      if (!split) return 2'd0;
      return f3[1] ? 2'd3 : 2'd1;
   endfunction

   // Access k of a request; split accesses are single bytes at addr+k, wrapping at 2^32.
   function automatic mem_acc_t make_access(input logic [31:0] addr,
                                            input logic [31:0] wdata,
                                            input logic [2:0]  f3,
                                            input logic        we,
                                            input logic        split,
                                            input logic [1:0]  k);
      mem_acc_t    a;
      logic [31:0] sh;
      sh      = wdata >> {k, 3'b000};
      a.addr  = addr + {30'd0, k};
      a.wdata = wdata;
      a.f3    = f3;
      if (split) begin
         a.f3    = we ? SB : LBU;
         a.wdata = {24'd0, sh[7:0]};
      end
      return a;
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-stage request/response bundle of the LSU; master is the execute stage,
// slave is the LSU. Requests are held off by req_ready, responses cannot be stalled.
interface lsu_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/lsu_load_ext.sv
// Combinational load result: pass-through for aligned loads, byte assembly plus
// sign/zero extension for split loads (last byte arrives live on read_data).
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic            split,
   input  logic [2:0]      funct3,
   input  logic [2:0][7:0] lo_bytes,
   input  logic [31:0]     read_data,
   output logic [31:0]     rdata
);
   logic sign;

   always_comb begin
      sign  = ~funct3[2] & read_data[7];
      rdata = read_data;
      if (split) begin
         if (funct3[1:0] == 2'b01)
            rdata = {{16{sign}}, read_data[7:0], lo_bytes[0]};
         else
            rdata = {read_data[7:0], lo_bytes[2], lo_bytes[1], lo_bytes[0]};
      end
   end
endmodule

// File: rtl/lsu_ctrl.sv
// RV32 load/store controller: one access for aligned requests, one byte per cycle
// for misaligned ones; response N+1 cycles after accept, req_ready only when idle.
module lsu_ctrl
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   lsu_ctrl_if.slave   req,
   output logic [31:0] mem_addr,
   output logic [31:0] write_data_M,
   output logic [2:0]  funct3,
   output logic        write_en,
   output logic        read_en,
   input  logic [31:0] read_data
);
   lsu_state_e      state;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [2:0]      f3_q;
   logic            we_q;
   logic            split_q;
   logic            err_q;
   logic [1:0]      cnt;
   logic [1:0]      last_q;
   logic [2:0][7:0] bytes_q;
   logic [31:0]     ext_rdata;
   logic            accept;
   logic            req_ill;
   logic            req_split;
   mem_acc_t        acc_first;
   mem_acc_t        acc_next;

   assign accept    = req.req_valid && (state == IDLE);
   assign req_ill   = is_illegal(req.req_funct3, req.req_we);
   assign req_split = !req_ill && is_misaligned(req.req_funct3, req.req_addr[1:0]);
   assign acc_first = make_access(req.req_addr, req.req_wdata, req.req_funct3,
                                  req.req_we, req_split, 2'd0);
   assign acc_next  = make_access(addr_q, wdata_q, f3_q, we_q, split_q, cnt + 2'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         f3_q         <= '0;
         we_q         <= 1'b0;
         split_q      <= 1'b0;
         err_q        <= 1'b0;
         cnt          <= '0;
         last_q       <= '0;
         bytes_q      <= '0;
         mem_addr     <= '0;
         write_data_M <= '0;
         funct3       <= '0;
         write_en     <= 1'b0;
         read_en      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q  <= req.req_addr;
                  wdata_q <= req.req_wdata;
                  f3_q    <= req.req_funct3;
                  we_q    <= req.req_we;
                  split_q <= req_split;
                  err_q   <= req_ill;
                  cnt     <= '0;
                  last_q  <= last_idx(req.req_funct3, req_split);
                  if (req_ill) begin
                     state <= RESP;
                  end else begin
                     state        <= ACCESS;
                     mem_addr     <= acc_first.addr;
                     write_data_M <= acc_first.wdata;
                     funct3       <= acc_first.f3;
                     write_en     <= req.req_we;
                     read_en      <= !req.req_we;
                  end
               end
            end
            ACCESS: begin
               // read_data now holds the byte fetched by the previous access
               if (cnt != 2'd0)
                  bytes_q[cnt - 2'd1] <= read_data[7:0];
               if (cnt == last_q) begin
                  state    <= RESP;
                  write_en <= 1'b0;
                  read_en  <= 1'b0;
               end else begin
                  cnt          <= cnt + 2'd1;
                  mem_addr     <= acc_next.addr;
                  write_data_M <= acc_next.wdata;
                  funct3       <= acc_next.f3;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   lsu_load_ext u_load_ext (
      .split     (split_q),
      .funct3    (f3_q),
      .lo_bytes  (bytes_q),
      .read_data (read_data),
      .rdata     (ext_rdata)
   );

   assign req.req_ready = (state == IDLE);
   assign req.rsp_valid = (state == RESP);
   assign req.rsp_err   = (state == RESP) && err_q;
   assign req.rsp_rdata = ((state == RESP) && !err_q && !we_q) ? ext_rdata : 32'd0;

endmodule
